// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel FSM state
// encoding and the reset-level state helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    HIGH  = 2'b00,
    WAIT0 = 2'b01,
    LOW   = 2'b10,
    WAIT1 = 2'b11
  } state_e;

  // State a channel settles into at reset (and on an illegal encoding).
  function automatic state_e rst_state(input logic lvl);
    return lvl ? HIGH : LOW;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 4-state FSM with a down-counting stability window
// and registered level / edge-tick outputs.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   CNT_W     = 21,
  parameter int   DB_COUNT  = 2**21-1,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_COUNT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, fall_q, rise_q;

  // Next-state decode: any reversion during a wait drops back with no credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HIGH: if (!sw_i) begin
        state_d = WAIT0;
        cnt_d   = LOAD;
      end
      WAIT0: if (!sw_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = LOW;
      end else begin
        state_d = HIGH;
      end
      LOW: if (sw_i) begin
        state_d = WAIT1;
        cnt_d   = LOAD;
      end
      WAIT1: if (sw_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = HIGH;
      end else begin
        state_d = LOW;
      end
      default: state_d = rst_state(RST_LEVEL);
    endcase
  end

  // State, counter and outputs; outputs decode the next state so the level
  // flip and the tick land on the same edge the FSM settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= rst_state(RST_LEVEL);
      cnt_q   <= '0;
      level_q <= RST_LEVEL;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == HIGH) || (state_d == WAIT0);
      fall_q  <= (state_q == WAIT0) && (state_d == LOW);
      rise_q  <= (state_q == WAIT1) && (state_d == HIGH);
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CH independent debounce_chan instances.
// Optional DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser per channel
// (reset to RST_LEVEL), adding 2 cycles to every latency.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   CH        = 4,
  parameter int   CNT_W     = 21,
  parameter int   DB_COUNT  = 2**21-1,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] fall_tick,
  output logic [CH-1:0] rise_tick
);

  logic [CH-1:0] sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous board pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= {CH{RST_LEVEL}};
      sync2_q <= {CH{RST_LEVEL}};
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_chan #(
      .CNT_W    (CNT_W),
      .DB_COUNT (DB_COUNT),
      .RST_LEVEL(RST_LEVEL)
    ) u_chan (
      .clk    (clk),
      .rst_n  (reset),
      .sw_i   (sw_s[g]),
      .level_o(db_level[g]),
      .fall_o (fall_tick[g]),
      .rise_o (rise_tick[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three configurations (DB_COUNT=5/RST=1,
// DB_COUNT=1/RST=1, DB_COUNT=5/RST=0) driven by the same inputs and compared
// every cycle against a run-length reference model, plus directed checks.
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYN = 2;
`else
  localparam int SYN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw = 4'hF;
  logic [3:0] lvl_o[3], fall_o[3], rise_o[3];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CH(4), .CNT_W(4), .DB_COUNT(5), .RST_LEVEL(1'b1)) u_a (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(lvl_o[0]), .fall_tick(fall_o[0]), .rise_tick(rise_o[0]));
  debounce_multi #(.CH(4), .CNT_W(4), .DB_COUNT(1), .RST_LEVEL(1'b1)) u_b (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(lvl_o[1]), .fall_tick(fall_o[1]), .rise_tick(rise_o[1]));
  debounce_multi #(.CH(4), .CNT_W(4), .DB_COUNT(5), .RST_LEVEL(1'b0)) u_c (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(lvl_o[2]), .fall_tick(fall_o[2]), .rise_tick(rise_o[2]));

  function automatic int db_of(input int d);
    return (d == 1) ? 1 : 5;
  endfunction
  function automatic logic rl_of(input int d);
    return (d == 2) ? 1'b0 : 1'b1;
  endfunction

  // Reference: a level flips once DB_COUNT+1 consecutive sampled inputs
  // disagree with it; any agreeing sample clears the run.
  logic [3:0] m_lvl[3], m_f[3], m_r[3], m_p0[3], m_p1[3];
  int         m_run[3][4];

  always @(posedge clk or negedge reset) begin
    logic [3:0] s;
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        m_lvl[d] = {4{rl_of(d)}};
        m_p0[d]  = {4{rl_of(d)}};
        m_p1[d]  = {4{rl_of(d)}};
        m_f[d]   = '0;
        m_r[d]   = '0;
        for (int c = 0; c < 4; c++) m_run[d][c] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        s = (SYN == 0) ? sw : m_p1[d];
        m_p1[d] = m_p0[d];
        m_p0[d] = sw;
        m_f[d] = '0;
        m_r[d] = '0;
        for (int c = 0; c < 4; c++) begin
          if (s[c] != m_lvl[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == db_of(d) + 1) begin
              m_lvl[d][c] = s[c];
              if (s[c]) m_r[d][c] = 1'b1;
              else      m_f[d][c] = 1'b1;
              m_run[d][c] = 0;
            end
          end else begin
            m_run[d][c] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("lvl%0d", d),  32'(lvl_o[d]),  32'(m_lvl[d]));
      check($sformatf("fall%0d", d), 32'(fall_o[d]), 32'(m_f[d]));
      check($sformatf("rise%0d", d), 32'(rise_o[d]), 32'(m_r[d]));
    end
  endtask

  // Drive a value, let one rising edge pass, compare at the falling edge.
  task automatic step(input logic [3:0] v);
    sw = v;
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    int la, lb, n, acc;
    logic [3:0] cur;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_lvl_a",  32'(lvl_o[0]), 32'hF);
    check("rst_fall_a", 32'(fall_o[0]), 32'h0);
    check("rst_rise_a", 32'(rise_o[0]), 32'h0);
    check("rst_lvl_c",  32'(lvl_o[2]), 32'h0);
    reset = 1'b1;
    step(4'hF);
    check("c_no_release_tick", 32'(rise_o[2]), 32'h0);
    repeat (12) step(4'hF);

    // Clean press and release on channel 0
    la = -1; lb = -1; n = 0;
    for (int i = 1; i <= 15; i++) begin
      step(4'b1110);
      if (fall_o[0][0]) begin n++; if (la < 0) la = i; end
      if (fall_o[1][0] && lb < 0) lb = i;
    end
    check("press_lat_a", 32'(la), 32'(6 + SYN));
    check("press_lat_b", 32'(lb), 32'(2 + SYN));
    check("press_pulses_a", 32'(n), 32'd1);
    la = -1; lb = -1;
    for (int i = 1; i <= 15; i++) begin
      step(4'hF);
      if (rise_o[0][0] && la < 0) la = i;
      if (rise_o[1][0] && lb < 0) lb = i;
    end
    check("release_lat_a", 32'(la), 32'(6 + SYN));
    check("release_lat_b", 32'(lb), 32'(2 + SYN));

    // Bounce on channel 1, then held low
    n = 0; la = -1;
    repeat (3) begin
      repeat (4) begin step(4'b1101); if (fall_o[0][1]) n++; end
      step(4'hF); if (fall_o[0][1]) n++;
    end
    for (int i = 1; i <= 12; i++) begin
      step(4'b1101);
      if (fall_o[0][1]) begin n++; if (la < 0) la = i; end
    end
    check("bounce_ticks_a", 32'(n), 32'd1);
    check("bounce_lat_a", 32'(la), 32'(6 + SYN));
    repeat (12) step(4'hF);

    // All channels together
    n = 0;
    repeat (12) begin step(4'h0); if (fall_o[0] == 4'hF) n++; end
    check("simul_all", 32'(n), 32'd1);
    repeat (12) step(4'hF);

    // Channel 2 reverts at the third cycle
    acc = 0;
    step(4'h0); step(4'h0);
    repeat (12) begin step(4'b0100); acc |= int'(fall_o[0]); end
    check("revert_ch2", 32'(acc), 32'b1011);
    repeat (12) step(4'hF);

    // Reset in the middle of a wait window
    repeat (3) step(4'b0111);
    #1 reset = 1'b0;
    #1;
    check("async_lvl_a",  32'(lvl_o[0]), 32'hF);
    check("async_fall_a", 32'(fall_o[0]), 32'h0);
    check("async_lvl_c",  32'(lvl_o[2]), 32'h0);
    @(negedge clk);
    sw = 4'hF;
    reset = 1'b1;
    acc = 0;
    repeat (12) begin step(4'hF); acc |= int'(fall_o[0] | rise_o[0]); end
    check("post_reset_ticks_a", 32'(acc), 32'h0);

    // Randomised bouncing inputs against the model
    cur = 4'hF;
    repeat (800) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      step(cur);
      if ($urandom_range(0, 15) == 0) repeat (8) step(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel switch/button debouncer. It is the successor to the single-channel debouncer in the UART front-panel path.
- Each of CH independent channels filters a raw contact input and produces the following outputs:
  - a stable level;
  - a one-cycle falling-edge tick;
  - a one-cycle rising-edge tick.
- The stability window is set by a parameter instead of a fixed 21-bit full count.
- Sits between board pins (buttons/DIP switches) and the UART control/test logic.

Parameters:
- CH, 4, number of independent channels (1..32).
- CNT_W, 21, width of each channel's stability counter.
- DB_COUNT, 2**21-1, consecutive stable cycles required after the first changed sample; legal range 1..2**CNT_W-1.
- RST_LEVEL, 1, level every channel assumes at reset (1 = released/high, 0 = low).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  CH  raw switch inputs, one bit per channel.
- db_level  output  CH  debounced level per channel, registered.
- fall_tick  output  CH  one-cycle pulse when db_level goes 1->0, registered.
- rise_tick  output  CH  one-cycle pulse when db_level goes 0->1, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - every channel state = HIGH if RST_LEVEL=1, else LOW;
  - counters = 0;
  - db_level = {CH{RST_LEVEL}};
  - fall_tick = rise_tick = 0.
- Per-channel FSM, 4 states: HIGH, WAIT0, LOW, WAIT1.
  - HIGH: if sw=0 -> WAIT0 and load cnt = DB_COUNT; else stay.
  - WAIT0:
    - sw=0: cnt = cnt-1; if the decremented value is 0 -> LOW.
    - sw=1: -> HIGH, no tick; cnt value is don't-care and is reloaded on the next entry.
  - LOW: if sw=1 -> WAIT1 and load cnt = DB_COUNT.
  - WAIT1: mirror of WAIT0; on the decremented value reaching 0 -> HIGH.
  - Illegal encoding -> state implied by RST_LEVEL, no tick.
- Outputs:
  - db_level = 1 in HIGH/WAIT0 and 0 in LOW/WAIT1, registered from the next-state decode. It therefore changes on the same edge the FSM enters LOW/HIGH.
  - fall_tick is high for exactly the one cycle after the WAIT0->LOW edge; rise_tick likewise for WAIT1->HIGH.
  - Ticks and the db_level change are coincident. A reset-level state never produces a tick at reset release.
- Latency: sw changes and is held.
  - Edge k samples the change (entry to WAIT).
  - db_level flips and the tick asserts after edge k+DB_COUNT, i.e. DB_COUNT+1 edges after the first changed sample.
- Any reversion of sw during WAIT aborts the change; the full window restarts on the next change. No partial credit.
- Channels are fully independent. Simultaneous events on any subset of channels produce simultaneous ticks in the same cycle.
- Counter arithmetic is unsigned CNT_W bits. Decrement occurs only in WAIT with the held level; 0 is never decremented (no wrap).
- DB_COUNT=1: the WAIT state lasts exactly one cycle if the input holds.
- Reset asserted mid-WAIT aborts immediately to the reset-level state; no tick is emitted.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined:
  - each sw bit passes through a 2-flop synchroniser clocked by clk before the FSM;
  - synchroniser flops reset to RST_LEVEL;
  - all latencies grow by exactly 2 cycles.
- Undefined: sw feeds the FSM directly; inputs must already be synchronous to clk; latency as stated above.

Decomposition:
- Package debounce_pkg:
  - state encoding constants HIGH=2'b00, WAIT0=2'b01, LOW=2'b10, WAIT1=2'b11;
  - state typedef.
- Sub-module debounce_chan:
  - one channel's FSM, counter and registered outputs;
  - parameters CNT_W, DB_COUNT, RST_LEVEL;
  - instantiated CH times in a generate loop.
- The optional synchroniser lives in the top level.

Test Plan:
All scenarios run with CH=4, CNT_W=4, DB_COUNT=5, RST_LEVEL=1, macro undefined unless stated.
- Clean press: sw[0] 1->0 and held.
  - db_level[0] falls and fall_tick[0]=1 for 1 cycle exactly 6 edges after the first low sample.
  - Release held gives rise_tick[0] with the same 6-edge timing.
- Bounce: sw[1] low for 4 cycles then high 1 cycle, repeated 3 times, then held low.
  - No tick during the bounces.
  - The tick comes 6 edges after the final low onset; db_level[1] never glitches.
- Simultaneous channels: sw=4'b0000 on one edge and held.
  - fall_tick=4'b1111 in the same single cycle.
  - Channel 2 reverts at cycle 3: only ticks for channels 0, 1 and 3.
- Reset mid-WAIT: sw[3] low 3 cycles, then reset pulsed low.
  - Outputs go to db_level=4'b1111 and ticks 0 asynchronously.
  - No tick after release while sw[3] is high.
- Boundaries:
  - DB_COUNT=1: tick 2 edges after the change.
  - RST_LEVEL=0: db_level=0 from reset and no tick at reset release.
  - DEBOUNCE_SYNC_EN defined: the clean-press tick arrives at 8 edges.
